mem_stream_reader: RTL and testbench
====================================

MEM_STREAM_READER -- requirements
Module: mem_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning word-address width of the attached on-chip data memory.
REQ-002 SHALL have parameter MEM_WORDS, default 342, meaning number of valid words in the attached memory.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2), meaning output buffer entries.
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a transfer.
REQ-007 SHALL have port base_addr  input  ADDR_W  first word address, sampled when start is accepted.
REQ-008 SHALL have port length  input  ADDR_W+1  word count, sampled when start is accepted.
REQ-009 SHALL have port busy  output  1  transfer in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse after the last word is accepted downstream.
REQ-011 SHALL have port err  output  1  one-cycle pulse when a start is rejected.
REQ-012 SHALL have ports mem_address (output, ADDR_W), mem_chipselect (output, 1), mem_write (output, 1), mem_byteenable (output, 4), mem_clken (output, 1), mem_writedata (output, 32), mem_readdata (input, 32): the memory slave port.
REQ-013 SHALL have ports src_data (output, 32), src_valid (output, 1), src_ready (input, 1), src_last (output, 1): the streaming output.

Function
REQ-014 SHALL drive mem_write=0, mem_writedata=0, mem_byteenable=4'hF and mem_clken=1 constantly.
REQ-015 SHALL treat memory read latency as exactly 1 cycle: an address with mem_chipselect=1 in cycle N returns mem_readdata that is valid in cycle N+1 and captured into the FIFO in that cycle.
REQ-016 SHALL implement states IDLE, READ, DRAIN; busy=1 in READ and DRAIN.
REQ-017 SHALL accept start only in IDLE; start in READ or DRAIN SHALL be ignored with no err.
REQ-018 SHALL reject start, by pulsing err the next cycle and staying in IDLE, when length==0 or base_addr+length > MEM_WORDS.
REQ-019 SHALL otherwise enter READ the next cycle, issuing addresses base_addr, base_addr+1, ... with no wrap-around.
REQ-020 SHALL issue a read in a cycle only if FIFO occupancy plus reads in flight is less than FIFO_DEPTH, and SHALL hold mem_chipselect=0 when no read is issued.
REQ-021 SHALL move from READ to DRAIN in the cycle after the last address issues, and from DRAIN to IDLE when the word flagged last is accepted (src_valid & src_ready).
REQ-022 SHALL pulse done in the same cycle as that final acceptance.
REQ-023 SHALL present src_data/src_last from the FIFO head, with src_valid = FIFO not empty; src_last=1 only on the final word of the transfer.
REQ-024 SHALL hold src_data, src_last and src_valid stable while src_valid=1 and src_ready=0.
REQ-025 SHALL sustain one word per cycle when src_ready is held at 1, with the first src_valid 2 cycles after start.
REQ-026 SHALL support a simultaneous FIFO push and pop in one cycle without changing occupancy.
REQ-027 SHALL accept a new start in the cycle done is pulsed only from the next cycle (IDLE).

Reset
REQ-028 SHALL, on reset_n low and regardless of clk, go to IDLE, empty the FIFO, cancel in-flight reads and drive busy, done, err, src_valid, src_last and mem_chipselect to 0, mem_address to 0 and src_data to 0.
REQ-029 SHALL discard a read in flight at reset; no word from an aborted transfer SHALL appear after reset_n rises.

Configuration
REQ-030 SHALL, with macro MEM_STREAM_READER_CHECKSUM_EN defined, add output checksum (32 bits), which is cleared on accepted start and adds every word accepted downstream modulo 2^32, stable from done until the next accepted start.
REQ-031 SHALL, without MEM_STREAM_READER_CHECKSUM_EN, omit the checksum port and logic entirely.

Verification
REQ-032 SHALL cover: memory preloaded with word i = i; base_addr=0, length=8, src_ready=1 -> data 0..7 on consecutive cycles, src_last on 7, done with word 7, busy low next cycle.
REQ-033 SHALL cover: base_addr=340, length=3 -> err pulse, no mem_chipselect, busy stays 0; base_addr=339, length=3 -> 339, 340, 341 delivered.
REQ-034 SHALL cover: length=16 with src_ready toggled 1 cycle on / 3 cycles off -> all 16 words in order, no loss or duplication, in-flight plus occupancy never above 4.
REQ-035 SHALL cover: start pulsed again mid-transfer -> ignored, original transfer completes unchanged, no err.
REQ-036 SHALL cover: reset_n asserted while in READ with 2 words in the FIFO -> all outputs 0 immediately; next start of length=2 delivers only the new words.
REQ-037 SHALL cover, with checksum enabled: length=4 over words 1, 2, 3, 0xFFFFFFFF -> checksum=0x00000005 at done.

Source files
------------

// File: rtl/mem_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : mem_stream_reader
// Brief    : Reads a contiguous block of words from a 1-cycle-latency on-chip
//            memory and streams them out over a valid/ready interface through
//            a small first-word-fall-through buffer.
// Options  : MEM_STREAM_READER_CHECKSUM_EN adds a 32-bit running checksum
//            output of all words accepted downstream.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stream_reader #(
    parameter int ADDR_W     = 9,
    parameter int MEM_WORDS  = 342,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    output logic [31:0]       src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_last
`ifdef MEM_STREAM_READER_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_END_W = ADDR_W + 2;

    localparam logic [c_CNT_W-1:0] c_DEPTH     = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_END_W-1:0] c_MEM_WORDS = c_END_W'(MEM_WORDS);
    localparam logic [ADDR_W-1:0]  c_ONE_ADDR  = 1;
    localparam logic [ADDR_W:0]    c_ONE_LEN   = 1;
    localparam logic [c_PTR_W-1:0] c_ONE_PTR   = 1;
    localparam logic [c_CNT_W-1:0] c_ONE_CNT   = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Control state
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     remain_q, remain_d;
    logic                err_q, err_d;
    logic                inflight_q, inflight_d;
    logic                inflight_last_q, inflight_last_d;

    // Output buffer
    logic [31:0]         fifo_data_q [FIFO_DEPTH];
    logic                fifo_last_q [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0]  count_q, count_d;

    // Combinational helpers
    logic                w_issue;
    logic                w_accept;
    logic                w_fifo_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_pop_fifo;
    logic [31:0]         w_head_data;
    logic                w_head_last;
    logic [c_CNT_W-1:0]  w_level;
    logic [c_END_W-1:0]  w_range_end;
    logic                w_start_bad;

    // Write side of the memory port is never used
    assign mem_write      = 1'b0;
    assign mem_writedata  = 32'd0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;

    assign mem_address    = addr_q;
    assign mem_chipselect = w_issue;
    assign busy           = (state_q != S_IDLE);
    assign err            = err_q;

    // A start is refused for an empty transfer or one running past the memory end
    assign w_range_end = {2'b00, base_addr} + {1'b0, length};
    assign w_start_bad = (length == '0) || (w_range_end > c_MEM_WORDS);

    // Words buffered plus the word coming back from memory; bounds read issue
    assign w_level = count_q + c_CNT_W'(inflight_q);

    // The word returning from memory is visible at the head in its arrival
    // cycle when the buffer is empty, so data reaches the output without an
    // extra buffering cycle.
    assign w_fifo_empty = (count_q == '0);
    assign w_head_data  = w_fifo_empty ? mem_readdata    : fifo_data_q[rd_ptr_q];
    assign w_head_last  = w_fifo_empty ? inflight_last_q : fifo_last_q[rd_ptr_q];

    assign src_valid = ~w_fifo_empty | inflight_q;
    assign src_data  = src_valid ? w_head_data : 32'd0;
    assign src_last  = src_valid & w_head_last;

    assign w_pop      = src_valid & src_ready;
    assign w_pop_fifo = w_pop & ~w_fifo_empty;
    // An arriving word consumed straight from the bypass is never stored
    assign w_push     = inflight_q & ~(w_fifo_empty & w_pop);

    assign done = w_pop & w_head_last & (state_q == S_DRAIN);

    // Transfer sequencing: accept/reject start, issue reads, wait for drain
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        err_d    = 1'b0;
        w_issue  = 1'b0;
        w_accept = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (w_start_bad) begin
                        err_d = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                        state_d  = S_READ;
                        addr_d   = base_addr;
                        remain_d = length;
                    end
                end
            end
            S_READ: begin
                if (w_level < c_DEPTH) begin
                    w_issue  = 1'b1;
                    addr_d   = addr_q + c_ONE_ADDR;
                    remain_d = remain_q - c_ONE_LEN;
                    if (remain_q == c_ONE_LEN) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_pop && w_head_last) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Read-in-flight tracking and buffer pointer/occupancy update
    always_comb begin
        inflight_d      = w_issue;
        inflight_last_d = w_issue & (remain_q == c_ONE_LEN);
        wr_ptr_d        = w_push     ? (wr_ptr_q + c_ONE_PTR) : wr_ptr_q;
        rd_ptr_d        = w_pop_fifo ? (rd_ptr_q + c_ONE_PTR) : rd_ptr_q;
        count_d         = count_q;
        case ({w_push, w_pop_fifo})
            2'b10:   count_d = count_q + c_ONE_CNT;
            2'b01:   count_d = count_q - c_ONE_CNT;
            default: count_d = count_q;
        endcase
    end

    // Control and pointer registers; reset also cancels any read in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            remain_q        <= '0;
            err_q           <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remain_q        <= remain_d;
            err_q           <= err_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
        end
    end

    // Buffer storage; contents are masked at the output while empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_data_q[wr_ptr_q] <= mem_readdata;
            fifo_last_q[wr_ptr_q] <= inflight_last_q;
        end
    end

`ifdef MEM_STREAM_READER_CHECKSUM_EN
    logic [31:0] sum_q;

    // Including the word accepted this cycle makes the total visible with done
    assign checksum = sum_q + (w_pop ? w_head_data : 32'd0);

    // Running sum of accepted words, restarted by each accepted start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= 32'd0;
        end else if (w_accept) begin
            sum_q <= 32'd0;
        end else if (w_pop) begin
            sum_q <= sum_q + w_head_data;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stream_reader
// Brief    : Directed self-checking bench for mem_stream_reader with a
//            1-cycle-latency memory model (word i holds value i).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stream_reader;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [8:0]  base_addr;
    logic [9:0]  length;
    logic        busy, done, err;
    logic [8:0]  mem_address;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata, mem_readdata;
    logic [31:0] src_data;
    logic        src_valid, src_ready, src_last;
`ifdef MEM_STREAM_READER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_model [0:511];

    mem_stream_reader #(
        .ADDR_W     (9),
        .MEM_WORDS  (342),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .length         (length),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata),
        .src_data       (src_data),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .src_last       (src_last)
`ifdef MEM_STREAM_READER_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: data for an address appears one cycle later
    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= mem_model[mem_address];
    end

    // Drive one cycle's inputs at the falling edge, then settle before sampling
    task automatic cycle(input logic st, input logic [8:0] b, input logic [9:0] l, input logic rdy);
        @(negedge clk);
        start     = st;
        base_addr = b;
        length    = l;
        src_ready = rdy;
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b0, 9'd0, 10'd0, 1'b0);
        cycle(1'b0, 9'd0, 10'd0, 1'b0);
        checks++;
        if ({busy, done, err, src_valid, src_last, mem_chipselect} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=000000", {busy, done, err, src_valid, src_last, mem_chipselect});
        end
        checks++;
        if (mem_address !== 9'd0 || src_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_data addr=%0d data=%h exp addr=0 data=0", mem_address, src_data);
        end
        checks++;
        if ({mem_write, mem_byteenable, mem_clken} !== 6'b0_1111_1 || mem_writedata !== 32'd0) begin
            failures++;
            $display("FAIL mem_constants got we=%b be=%h ce=%b wd=%h", mem_write, mem_byteenable, mem_clken, mem_writedata);
        end
    endtask

    task automatic test_basic();
        cycle(1'b1, 9'd0, 10'd8, 1'b1);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_c0 got=%b exp=0", busy); end
        cycle(1'b0, 9'd0, 10'd0, 1'b1);
        checks++;
        if (busy !== 1'b1 || src_valid !== 1'b0 || mem_chipselect !== 1'b1 || mem_address !== 9'd0) begin
            failures++;
            $display("FAIL basic_c1 busy=%b valid=%b cs=%b addr=%0d exp 1 0 1 0", busy, src_valid, mem_chipselect, mem_address);
        end
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 9'd0, 10'd0, 1'b1);
            checks++;
            if (src_valid !== 1'b1 || src_data !== 32'(k) || src_last !== (k == 7) || done !== (k == 7)) begin
                failures++;
                $display("FAIL basic_word%0d valid=%b data=%0d last=%b done=%b exp 1 %0d %b %b",
                         k, src_valid, src_data, src_last, done, k, (k == 7), (k == 7));
            end
        end
        cycle(1'b0, 9'd0, 10'd0, 1'b1);
        checks++;
        if (busy !== 1'b0 || src_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_end busy=%b valid=%b exp 0 0", busy, src_valid);
        end
    endtask

    task automatic test_error();
        cycle(1'b1, 9'd340, 10'd3, 1'b1);
        cycle(1'b0, 9'd0, 10'd0, 1'b1);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || mem_chipselect !== 1'b0) begin
            failures++;
            $display("FAIL err_range err=%b busy=%b cs=%b exp 1 0 0", err, busy, mem_chipselect);
        end
        cycle(1'b0, 9'd0, 10'd0, 1'b1);
        checks++;
        if (err !== 1'b0 || busy !== 1'b0 || mem_chipselect !== 1'b0) begin
            failures++;
            $display("FAIL err_pulse err=%b busy=%b cs=%b exp 0 0 0", err, busy, mem_chipselect);
        end
        cycle(1'b1, 9'd5, 10'd0, 1'b1);
        cycle(1'b0, 9'd0, 10'd0, 1'b1);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL err_len0 err=%b busy=%b exp 1 0", err, busy);
        end
        cycle(1'b1, 9'd339, 10'd3, 1'b1);
        cycle(1'b0, 9'd0, 10'd0, 1'b1);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL edge_accept err=%b busy=%b exp 0 1", err, busy);
        end
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 9'd0, 10'd0, 1'b1);
            checks++;
            if (src_valid !== 1'b1 || src_data !== 32'(339 + k) || src_last !== (k == 2) || done !== (k == 2)) begin
                failures++;
                $display("FAIL edge_word%0d valid=%b data=%0d last=%b done=%b exp 1 %0d %b %b",
                         k, src_valid, src_data, src_last, done, 339 + k, (k == 2), (k == 2));
            end
        end
        cycle(1'b0, 9'd0, 10'd0, 1'b1);
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 9'd10, 10'd2, 1'b1);
        cycle(1'b0, 9'd0, 10'd0, 1'b1);
        cycle(1'b0, 9'd0, 10'd0, 1'b1);
        checks++;
        if (src_valid !== 1'b1 || src_data !== 32'd10 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_word0 valid=%b data=%0d done=%b exp 1 10 0", src_valid, src_data, done);
        end
        // start presented in the done cycle must be ignored
        cycle(1'b1, 9'd30, 10'd1, 1'b1);
        checks++;
        if (src_data !== 32'd11 || src_last !== 1'b1 || done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_word1 data=%0d last=%b done=%b exp 11 1 1", src_data, src_last, done);
        end
        cycle(1'b1, 9'd30, 10'd1, 1'b1);
        checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ignored busy=%b err=%b exp 0 0", busy, err);
        end
        cycle(1'b0, 9'd0, 10'd0, 1'b1);
        checks++;
        if (busy !== 1'b1 || mem_chipselect !== 1'b1 || mem_address !== 9'd30) begin
            failures++;
            $display("FAIL b2b_restart busy=%b cs=%b addr=%0d exp 1 1 30", busy, mem_chipselect, mem_address);
        end
        cycle(1'b0, 9'd0, 10'd0, 1'b1);
        checks++;
        if (src_valid !== 1'b1 || src_data !== 32'd30 || src_last !== 1'b1 || done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_single valid=%b data=%0d last=%b done=%b exp 1 30 1 1", src_valid, src_data, src_last, done);
        end
        cycle(1'b0, 9'd0, 10'd0, 1'b1);
    endtask

    task automatic test_mid_start();
        cycle(1'b1, 9'd20, 10'd6, 1'b1);
        for (int n = 1; n <= 8; n++) begin
            // an out-of-range start mid-transfer would raise err if not ignored
            cycle((n == 3), 9'd300, 10'd100, 1'b1);
            checks++;
            if (err !== 1'b0) begin failures++; $display("FAIL mid_err n=%0d got=%b exp=0", n, err); end
            if (n >= 2 && n <= 7) begin
                checks++;
                if (src_valid !== 1'b1 || src_data !== 32'(18 + n) || src_last !== (n == 7) || done !== (n == 7)) begin
                    failures++;
                    $display("FAIL mid_word n=%0d valid=%b data=%0d last=%b done=%b exp 1 %0d %b %b",
                             n, src_valid, src_data, src_last, done, 18 + n, (n == 7), (n == 7));
                end
            end
        end
        checks++;
        if (busy !== 1'b0 || src_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_end busy=%b valid=%b exp 0 0", busy, src_valid);
        end
    endtask

    task automatic test_backpressure();
        int idx = 0, issued = 0, accepted = 0, max_level = 0;
        logic got_done = 1'b0;
        logic prev_hold = 1'b0;
        logic [31:0] prev_data = '0;
        logic prev_last = 1'b0;
        logic rdy;
        cycle(1'b1, 9'd0, 10'd16, 1'b1);
        for (int n = 1; n < 300 && !got_done; n++) begin
            rdy = ((n % 4) == 1);
            cycle(1'b0, 9'd0, 10'd0, rdy);
            if (mem_chipselect) issued++;
            if (issued - accepted > max_level) max_level = issued - accepted;
            if (prev_hold) begin
                checks++;
                if (src_valid !== 1'b1 || src_data !== prev_data || src_last !== prev_last) begin
                    failures++;
                    $display("FAIL bp_hold n=%0d valid=%b data=%0d last=%b exp 1 %0d %b", n, src_valid, src_data, src_last, prev_data, prev_last);
                end
            end
            if (src_valid && rdy) begin
                checks++;
                if (src_data !== 32'(idx) || src_last !== (idx == 15) || done !== (idx == 15)) begin
                    failures++;
                    $display("FAIL bp_word%0d data=%0d last=%b done=%b exp %0d %b %b", idx, src_data, src_last, done, idx, (idx == 15), (idx == 15));
                end
                if (done) got_done = 1'b1;
                idx++;
                accepted++;
            end else if (done) begin
                checks++;
                failures++;
                $display("FAIL bp_spurious_done n=%0d got=1 exp=0", n);
            end
            prev_hold = src_valid & ~rdy;
            prev_data = src_data;
            prev_last = src_last;
        end
        checks++;
        if (got_done !== 1'b1 || idx != 16) begin
            failures++;
            $display("FAIL bp_complete done_seen=%b words=%0d exp 1 16", got_done, idx);
        end
        checks++;
        if (max_level > 4) begin
            failures++;
            $display("FAIL bp_level max=%0d exp<=4", max_level);
        end
        cycle(1'b0, 9'd0, 10'd0, 1'b1);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL bp_end busy=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 9'd50, 10'd8, 1'b0);
        for (int n = 1; n <= 4; n++) cycle(1'b0, 9'd0, 10'd0, 1'b0);
        checks++;
        if (busy !== 1'b1 || src_valid !== 1'b1 || src_data !== 32'd50) begin
            failures++;
            $display("FAIL rst_pre busy=%b valid=%b data=%0d exp 1 1 50", busy, src_valid, src_data);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, src_valid, src_last, mem_chipselect} !== 6'b0 || mem_address !== 9'd0 || src_data !== 32'd0) begin
            failures++;
            $display("FAIL rst_async ctrl=%b addr=%0d data=%h exp 000000 0 0",
                     {busy, done, err, src_valid, src_last, mem_chipselect}, mem_address, src_data);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1'b1, 9'd60, 10'd2, 1'b1);
        checks++;
        if (src_valid !== 1'b0) begin failures++; $display("FAIL rst_stale_c0 valid=%b data=%0d exp valid 0", src_valid, src_data); end
        cycle(1'b0, 9'd0, 10'd0, 1'b1);
        checks++;
        if (src_valid !== 1'b0) begin failures++; $display("FAIL rst_stale_c1 valid=%b data=%0d exp valid 0", src_valid, src_data); end
        cycle(1'b0, 9'd0, 10'd0, 1'b1);
        checks++;
        if (src_valid !== 1'b1 || src_data !== 32'd60 || src_last !== 1'b0) begin
            failures++;
            $display("FAIL rst_new0 valid=%b data=%0d last=%b exp 1 60 0", src_valid, src_data, src_last);
        end
        cycle(1'b0, 9'd0, 10'd0, 1'b1);
        checks++;
        if (src_valid !== 1'b1 || src_data !== 32'd61 || src_last !== 1'b1 || done !== 1'b1) begin
            failures++;
            $display("FAIL rst_new1 valid=%b data=%0d last=%b done=%b exp 1 61 1 1", src_valid, src_data, src_last, done);
        end
        cycle(1'b0, 9'd0, 10'd0, 1'b1);
        checks++;
        if (busy !== 1'b0 || src_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_end busy=%b valid=%b exp 0 0", busy, src_valid);
        end
    endtask

`ifdef MEM_STREAM_READER_CHECKSUM_EN
    task automatic test_checksum();
        logic seen = 1'b0;
        mem_model[100] = 32'd1;
        mem_model[101] = 32'd2;
        mem_model[102] = 32'd3;
        mem_model[103] = 32'hFFFF_FFFF;
        cycle(1'b1, 9'd100, 10'd4, 1'b1);
        for (int n = 1; n < 20 && !seen; n++) begin
            cycle(1'b0, 9'd0, 10'd0, 1'b1);
            if (done) begin
                seen = 1'b1;
                checks++;
                if (checksum !== 32'h0000_0005) begin
                    failures++;
                    $display("FAIL csum_done got=%h exp=00000005", checksum);
                end
            end
        end
        cycle(1'b0, 9'd0, 10'd0, 1'b1);
        checks++;
        if (seen !== 1'b1 || checksum !== 32'h0000_0005) begin
            failures++;
            $display("FAIL csum_hold done_seen=%b got=%h exp 1 00000005", seen, checksum);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 512; i++) mem_model[i] = (i < 342) ? 32'(i) : 32'hDEAD_0000;
        mem_readdata = 32'd0;
        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        src_ready = 1'b0;
        test_reset();
        @(negedge clk);
        reset_n = 1'b1;
        test_basic();
        test_error();
        test_back_to_back();
        test_mid_start();
        test_backpressure();
        test_reset_mid();
`ifdef MEM_STREAM_READER_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
